cpu_seq: RTL

Multi-cycle fetch/decode/execute sequencer for the 4-bit-opcode CPU. It owns the program counter, instruction register and carry/zero flag registers, and fetches instruction bytes over a request/acknowledge memory port. It presents the current opcode and flags to the instruction decoder, then converts the decoder's level outputs into single-cycle datapath write strobes, jump loads and halt. It sits between instruction memory, the decoder and the A/B/register-file/ALU datapath.

---
 rtl/cpu_seq_if.sv | 23 ++
 rtl/cpu_seq.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/cpu_seq_if.sv
// rtl/cpu_seq_if.sv - instruction fetch port between cpu_seq and instruction memory
interface cpu_seq_if #(
  parameter int PC_W = 8
);
  logic [PC_W-1:0] mem_addr;
  logic            mem_req;
  logic            mem_ack;
  logic [7:0]      mem_rdata;

  modport master (
    output mem_addr,
    output mem_req,
    input  mem_ack,
    input  mem_rdata
  );

  modport slave (
    input  mem_addr,
    input  mem_req,
    output mem_ack,
    output mem_rdata
  );
endinterface

// File: rtl/cpu_seq.sv
// rtl/cpu_seq.sv - multi-cycle fetch/decode/execute sequencer owning PC, IR, TGT and flags
module cpu_seq #(
  parameter int PC_W     = 8,
  parameter int RESET_PC = 0
) (
  input  logic            clk,
  input  logic            rst,
  cpu_seq_if.master       mem,
  output logic [3:0]      ins,
  output logic [3:0]      operand,
  output logic            carry,
  output logic            zero,
  input  logic            dec_aload,
  input  logic            dec_bload,
  input  logic            dec_dsel,
  input  logic            dec_rfload,
  input  logic            dec_opsel,
  input  logic            dec_jump,
  input  logic            dec_hlt,
  input  logic            alu_carry,
  input  logic            alu_zero,
  output logic            a_we,
  output logic            b_we,
  output logic            rf_we,
  output logic            d_sel,
  output logic            op_sel,
  output logic [PC_W-1:0] pc,
  input  logic            run,
  output logic            halted
);

  localparam logic [PC_W-1:0] PC_INIT = PC_W'(RESET_PC);

  typedef enum logic [2:0] {
    S_BOOT,
    S_FETCH,
    S_DECODE,
    S_FETCH2,
    S_EXEC,
    S_HALT
  } state_t;

  state_t          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [7:0]      ir_q, ir_d;
  logic [7:0]      tgt_q, tgt_d;
  logic            carry_q, carry_d;
  logic            zero_q, zero_d;
  logic            any_we;
  logic            two_byte;

  // Length depends on the opcode alone so fetch timing never waits on the decoder.
  assign two_byte = (ir_q[7:4] >= 4'd6) && (ir_q[7:4] <= 4'd12);
  assign any_we   = dec_aload | dec_bload | dec_rfload;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_BOOT;
      pc_q    <= PC_INIT;
      ir_q    <= 8'h00;
      tgt_q   <= 8'h00;
      carry_q <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      tgt_q   <= tgt_d;
      carry_q <= carry_d;
      zero_q  <= zero_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    ir_d        = ir_q;
    tgt_d       = tgt_q;
    carry_d     = carry_q;
    zero_d      = zero_q;
    mem.mem_req = 1'b0;
    a_we        = 1'b0;
    b_we        = 1'b0;
    rf_we       = 1'b0;
    d_sel       = 1'b0;
    op_sel      = 1'b0;
    halted      = 1'b0;

    case (state_q)
      S_BOOT: state_d = S_FETCH;

      S_FETCH: begin
        mem.mem_req = 1'b1;
        if (mem.mem_ack) begin
          ir_d    = mem.mem_rdata;
          pc_d    = pc_q + PC_W'(1);
          state_d = S_DECODE;
        end
      end

      S_DECODE: state_d = two_byte ? S_FETCH2 : S_EXEC;

      S_FETCH2: begin
        mem.mem_req = 1'b1;
        if (mem.mem_ack) begin
          tgt_d   = mem.mem_rdata;
          pc_d    = pc_q + PC_W'(1);
          state_d = S_EXEC;
        end
      end

      S_EXEC: begin
        a_we   = dec_aload;
        b_we   = dec_bload;
        rf_we  = dec_rfload;
        // Selects are only meaningful alongside a strobe; keep them quiet otherwise.
        d_sel  = dec_dsel & any_we;
        op_sel = dec_opsel & any_we;
        if (dec_jump) pc_d = PC_W'(tgt_q);
        if (dec_rfload) begin
          carry_d = alu_carry;
          zero_d  = alu_zero;
        end
        state_d = dec_hlt ? S_HALT : S_FETCH;
      end

      S_HALT: begin
        halted = 1'b1;
        if (run) state_d = S_FETCH;
      end

      default: state_d = S_BOOT;
    endcase
  end

  assign mem.mem_addr = pc_q;
  assign pc           = pc_q;
  assign ins          = ir_q[7:4];
  assign operand      = ir_q[3:0];
  assign carry        = carry_q;
  assign zero         = zero_q;

endmodule
